// File: rtl/fb_pkg.sv
// Shared types and widths for the frame-buffer arbiter and its write buffer.
// Pure declarations: no latency, no flow control.
package fb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 9;
  localparam int FB_DBG_W  = 16;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR,
    GNT_WR_FORCED
  } gnt_e;

endpackage

// File: rtl/fb_wbuf.sv
// Synchronous FIFO: an entry pushed in cycle N is visible at the head in N+1.
// Backpressure: a push while full is refused, even if a pop happens in the same cycle.
module fb_wbuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: reads win, buffered writes drain in idle cycles, read data 2 cycles after grant.
// Backpressure: wr_ready drops while the write buffer is full; a long-full buffer forces one write and drops that read.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [FB_DBG_W-1:0] stall_cnt
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIM) + 1;

  gnt_e                gnt;
  logic                wb_push, wb_full, wb_empty;
  logic [ENT_W-1:0]    wb_head;
  logic [CNT_W-1:0]    wb_level_unused;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                force_wr, is_wr;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic [FB_DBG_W-1:0] stall_q, stall_d;
  logic                rd_pend_q, rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_wdata_q;

  assign {head_addr, head_data} = wb_head;
  assign wr_ready = !rst && !wb_full;
  assign wb_push  = wr_req && wr_ready;
  assign is_wr    = (gnt == GNT_WR) || (gnt == GNT_WR_FORCED);

  fb_wbuf #(
    .WIDTH(ENT_W),
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (wb_push),
    .din_i  ({wr_addr, wr_data}),
    .pop_i  (is_wr),
    .dout_o (wb_head),
    .full_o (wb_full),
    .empty_o(wb_empty),
    .count_o(wb_level_unused)
  );

  // Full implies non-empty, so a forced grant always has a head to write.
  assign force_wr = wb_full && (starve_q == STV_W'(STARVE_LIM - 1));

  always_comb begin
    gnt = GNT_IDLE;
    if (!rst) begin
      if (force_wr)       gnt = GNT_WR_FORCED;
      else if (rd_req)    gnt = GNT_RD;
      else if (!wb_empty) gnt = GNT_WR;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = hold_addr_q;
    mem_wdata = hold_wdata_q;
    unique case (gnt)
      GNT_RD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WR, GNT_WR_FORCED: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      GNT_IDLE: begin
      end
    endcase
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_comb begin
    starve_d = (wb_full && !is_wr) ? starve_q + 1'b1 : '0;
    stall_d  = stall_q;
    if (wr_req && !wr_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      stall_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      starve_q     <= starve_d;
      stall_q      <= stall_d;
      rd_pend_q    <= (gnt == GNT_RD);
      rd_valid_q   <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= mem_rdata;
      hold_addr_q  <= mem_addr;
      hold_wdata_q <= mem_wdata;
    end
  end

  assign rd_valid  = rd_valid_q && !rst;
  assign rd_data   = rd_data_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed test-plan steps then random traffic, checked against a queue-based model.
module tb_fb_arbiter;

  localparam int LIM   = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [16:0] a;
    logic [8:0]  d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rd_req, wr_req, rd_valid, wr_ready, mem_en, mem_we;
  logic [16:0] rd_addr, wr_addr, mem_addr;
  logic [8:0]  rd_data, wr_data, mem_wdata, mem_rdata;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // RAM model: unwritten words return a fixed pattern
  logic [8:0] ram [256];
  bit         ram_wr [256];

  function automatic logic [8:0] init_val(input int a);
    return (a == 16) ? 9'h1A5 : 9'(a * 7 + 3);
  endfunction

  function automatic logic [8:0] ram_rd(input int a);
    return ram_wr[a] ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        ram[mem_addr[7:0]]    <= mem_wdata;
        ram_wr[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= ram_rd(int'(mem_addr[7:0]));
      end
    end
  end

  // Reference model state
  int          n_chk = 0, n_pass = 0, dut_forced = 0;
  ent_t        mq[$];
  int          starve_m = 0, stall_m = 0;
  bit          pend_v = 0, rdv_m = 0, init_done = 0, m_acc = 0;
  logic [8:0]  pend_d = '0, rdd_m = '0, hold_d = '0;
  logic [16:0] hold_a = '0;
  logic [8:0]  exp_ram [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input bit rs, input bit r, input logic [16:0] ra,
                      input bit w, input logic [16:0] wa, input logic [8:0] wd);
    bit          full, do_rd, do_wr;
    logic [16:0] e_a;
    logic [8:0]  e_d;
    ent_t        head;
    @(posedge clk);
    #1;
    rst = rs; rd_req = r; rd_addr = ra; wr_req = w; wr_addr = wa; wr_data = wd;
    #4;
    full  = (mq.size() == DEPTH);
    do_rd = 1'b0;
    do_wr = 1'b0;
    m_acc = 1'b0;
    head  = '0;
    if (!rs) begin
      if (full && starve_m == LIM - 1) do_wr = 1'b1;
      else if (r)                      do_rd = 1'b1;
      else if (mq.size() > 0)          do_wr = 1'b1;
    end
    e_a = rs ? 17'h0 : hold_a;
    e_d = rs ? 9'h0 : hold_d;
    if (do_rd) e_a = ra;
    if (do_wr) begin
      head = mq[0];
      e_a  = head.a;
      e_d  = head.d;
    end
    chk("mem_en",    32'(mem_en),    32'(do_rd || do_wr));
    chk("mem_we",    32'(mem_we),    32'(do_wr));
    chk("mem_addr",  32'(mem_addr),  32'(e_a));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_d));
    chk("wr_ready",  32'(wr_ready),  32'(!rs && !full));
    chk("rd_valid",  32'(rd_valid),  32'(!rs && rdv_m));
    if (init_done) begin
      chk("rd_data",   32'(rd_data),   32'(rdd_m));
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    end
    if (!rs && r && mem_we === 1'b1) dut_forced++;

    if (rs) begin
      mq.delete();
      starve_m = 0; stall_m = 0;
      pend_v = 1'b0; rdv_m = 1'b0; rdd_m = '0;
      hold_a = '0; hold_d = '0;
      init_done = 1'b1;
    end else begin
      rdv_m = pend_v;
      if (pend_v) rdd_m = pend_d;
      pend_v = do_rd;
      if (do_rd) pend_d = exp_ram[ra[7:0]];
      if (do_wr) begin
        exp_ram[head.a[7:0]] = head.d;
        void'(mq.pop_front());
      end
      hold_a = e_a;
      hold_d = e_d;
      starve_m = (full && !do_wr) ? starve_m + 1 : 0;
      if (w && full && stall_m < 65535) stall_m++;
      if (w && !full) begin
        mq.push_back('{a: wa, d: wd});
        m_acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 17'h0, 1'b0, 17'h0, 9'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries, pct;
    for (int i = 0; i < 256; i++) exp_ram[i] = init_val(i);
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0;

    // Reset held 2 cycles with both requesters active
    step(1'b1, 1'b1, 17'h5, 1'b1, 17'h7, 9'h077);
    step(1'b1, 1'b1, 17'h5, 1'b1, 17'h7, 9'h077);
    idle(1);

    // Read latency
    step(1'b0, 1'b1, 17'h00010, 1'b0, 17'h0, 9'h0);
    idle(2);
    chk("read_lat_valid", 32'(rd_valid), 32'h1);
    chk("read_lat_data",  32'(rd_data),  32'h1A5);

    // Write drain
    step(1'b0, 1'b0, 17'h0, 1'b1, 17'h1, 9'h011);
    step(1'b0, 1'b0, 17'h0, 1'b1, 17'h2, 9'h022);
    step(1'b0, 1'b0, 17'h0, 1'b1, 17'h3, 9'h033);
    idle(3);
    chk("drain_ram1", 32'(ram_rd(1)), 32'h011);
    chk("drain_ram2", 32'(ram_rd(2)), 32'h022);
    chk("drain_ram3", 32'(ram_rd(3)), 32'h033);

    // Reads hog the RAM; 5th write waits on the starvation guard
    dut_forced = 0;
    for (int i = 0; i < 5; i++) begin
      tries = 0;
      do begin
        step(1'b0, 1'b1, 17'h00010, 1'b1, 17'(32 + i), 9'(9'h100 + i));
        tries++;
      end while (!m_acc && tries < 20);
    end
    chk("forced_writes", 32'(dut_forced), 32'd1);
    chk("stall_after_full", 32'(stall_cnt), 32'd8);
    step(1'b0, 1'b1, 17'h00011, 1'b0, 17'h0, 9'h0);
    step(1'b0, 1'b1, 17'h00012, 1'b0, 17'h0, 9'h0);
    idle(6);

    // Reset with writes buffered and a read in flight
    step(1'b1, 1'b0, 17'h0, 1'b0, 17'h0, 9'h0);
    step(1'b0, 1'b1, 17'h4, 1'b1, 17'h8, 9'h0AA);
    step(1'b0, 1'b1, 17'h5, 1'b1, 17'h9, 9'h0BB);
    step(1'b0, 1'b1, 17'h6, 1'b0, 17'h0, 9'h0);
    step(1'b1, 1'b0, 17'h0, 1'b0, 17'h0, 9'h0);
    idle(4);
    chk("midrst_stall", 32'(stall_cnt), 32'd0);
    chk("midrst_ready", 32'(wr_ready),  32'd1);

    // Random traffic at varying read pressure
    for (int seg = 0; seg < 4; seg++) begin
      pct = (seg == 3) ? 100 : 20 + seg * 35;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < pct, 17'($urandom_range(0, 63)),
             $urandom_range(0, 99) < 60, 17'($urandom_range(0, 63)),
             9'($urandom_range(0, 511)));
      end
    end
    idle(8);
    for (int a = 0; a < 64; a++) chk($sformatf("ram_%0d", a), 32'(ram_rd(a)), 32'(exp_ram[a]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between two requesters: the VGA scan-out reader and the camera pixel writer.
- VGA reads have priority; camera writes are absorbed by a small write buffer and drained in cycles with no read.
- A starvation guard forces a write when the buffer stays full.
- Sits between camera_ctrl (write side), vga_ctrl (read side) and the RAM, all in the qu_clk domain.

Parameters:
- ADDR_W, 17, frame-buffer word address width.
- DATA_W, 9, pixel width (RGB 3:3:3).
- WBUF_DEPTH, 4, write-buffer entries (power of two, ≥2).
- STARVE_LIM, 8, consecutive buffer-full cycles before a write is forced.

Ports:
- clk  in  1  system clock (qu_clk).
- rst  in  1  synchronous reset, active-high.
- rd_req  in  1  VGA read request, one word per cycle.
- rd_addr  in  ADDR_W  read address.
- rd_valid  out  1  rd_data holds the result of the read requested 2 cycles earlier.
- rd_data  out  DATA_W  read data, registered.
- wr_req  in  1  camera write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle when wr_req && wr_ready.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read enable.
- stall_cnt  out  16  saturating count of cycles with wr_req && !wr_ready (debug LEDs).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs 0, including rd_valid, rd_data, wr_ready, mem_* and stall_cnt. Buffer is emptied, starvation counter cleared.
- wr_ready goes 1 on the first cycle after rst deasserts.
- Write buffer: synchronous FIFO of {wr_addr, wr_data}.
  - wr_ready = !full, computed from the registered count.
  - A push and a pop in the same cycle when full: the push is refused.
  - An entry accepted at cycle N is issuable at N+1 at the earliest.
- Per-cycle grant (combinational from registered state and rd_req; drives mem_* the same cycle):
  - GNT_RD: rd_req && !force. Outputs mem_en=1, mem_we=0, mem_addr=rd_addr.
  - GNT_WR: !rd_req && buffer non-empty. Pop the head; mem_en=1, mem_we=1, head addr/data driven.
  - GNT_WR_FORCED: force=1 && buffer non-empty. Same as GNT_WR. The coincident read is dropped.
  - GNT_IDLE: otherwise. mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last value.
- Starvation counter:
  - Increments each cycle the buffer is full and the grant is not a write.
  - Clears on any write grant or when the buffer is not full.
  - force = (counter == STARVE_LIM−1) && full.
- Read pipeline:
  - GNT_RD at cycle N → mem_rdata sampled at N+1 into rd_data → rd_valid=1 and rd_data valid at N+2.
  - A dropped read gives rd_valid=0 at N+2; rd_data holds its previous value.
  - rd_data changes only when rd_valid is asserted.
- Hazard: no forwarding. A read of an address with a pending buffered write returns the old RAM contents. This is accepted behaviour (one-frame tear, invisible).
- stall_cnt saturates at 16'hFFFF and clears only on rst.
- Reset mid-operation:
  - Buffered writes are discarded; no mem_we on the reset cycle or after.
  - In-flight reads are squashed: rd_valid=0 the cycle after rst.
- Address width is full ADDR_W with no range check; out-of-range frame addresses are the requester's responsibility.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W=17 and FB_DATA_W=9.
  - The grant enum {GNT_IDLE, GNT_RD, GNT_WR, GNT_WR_FORCED}.
  - The 16-bit debug counter width.
- One natural sub-module: fb_wbuf. It is the synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth, and reusable by camera_ctrl.

Test Plan:
- Reset: hold rst 2 cycles with rd_req=1 and wr_req=1 → all outputs 0 during reset; wr_ready=1 on the first cycle after release; no mem_we during reset.
- Read latency: rd_req at cycle N with rd_addr=0x00010, RAM model holding 0x1A5 → mem_en=1, mem_we=0, mem_addr=0x00010 at N; rd_valid=1, rd_data=0x1A5 at N+2.
- Write drain: rd_req=0; push (0x1,0x011), (0x2,0x022), (0x3,0x033) at N..N+2 → mem_we=1 at N+1..N+3 with the addresses in order; the RAM then contains those values.
- Priority and full: rd_req held at 1; push 5 writes back-to-back → wr_ready=0 after the 4th accept; stall_cnt increments every cycle wr_req is held.
- Starvation: continuing the previous case, after 8 full cycles one GNT_WR_FORCED write of the oldest entry occurs; rd_valid=0 two cycles later; wr_ready returns to 1 the next cycle.
- Mid-operation reset: 2 entries buffered and a read in flight, assert rst for 1 cycle → no mem_we after; rd_valid=0 the next cycle; buffer is empty and stall_cnt=0 after release.
